// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN    = 32;
    localparam int unsigned INSTR_BYTES   = 4;
    localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;

    // Prefetch entry at the default machine width; the fetch unit derives its own from XLEN.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop with flush, head read straight from the storage registers.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // The issue credit rule keeps pushes off a full FIFO unless the head leaves in the same cycle.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            assert (!full || pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipelined instruction fetch: PC register, credit-limited memory requests, stale-response
// dropping after redirect, and a prefetch FIFO toward decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter int unsigned      CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_CLR = ~XLEN'(PC_ALIGN_MASK);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  redirect_aligned;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_use;
    logic             req_fire;
    logic             resp_keep;
    logic             fifo_empty;
    entry_t           push_entry;
    entry_t           head_entry;

    // Every issued request reserves a FIFO slot until its instruction is popped or dropped.
    assign in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
    assign mem_req_valid = rst_n && fetch_en && !redirect_valid
                           && (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign mem_req_addr  = fetch_pc;

    assign req_fire         = mem_req_valid && mem_req_ready;
    assign resp_keep        = mem_resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(mem_resp_valid);
    assign redirect_aligned = redirect_pc & ALIGN_CLR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the abandoned path.
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + PC_STEP;
                end else if (mem_resp_valid) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = resp_pc;
        push_entry.instr = mem_resp_data;
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (resp_keep),
        .din   (push_entry),
        .pop   (instr_ready),
        .dout  (head_entry),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr_out   = head_entry.instr;
    assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable memory model and a pop scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        int          epoch;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    pend_t       pend[$];
    exp_t        exp_q[$];
    exp_t        pop_log[$];
    int          pop_cyc[$];
    logic [31:0] req_log[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int epoch = 0;
    int lat   = 1;
    int pre;

    // addi x(n), x0, n for word n: gives 0->00000013, 4->00100093, 8->00200113.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        return {w[11:0], 5'd0, 3'd0, w[4:0], 7'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: present any due response, score pops, log requests, then advance to the next negedge.
    task automatic tick();
        exp_t  e;
        pend_t p;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend[0].data;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        if (instr_valid && instr_ready && !redirect_valid) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL sb_underflow observed pc=%h expected=no entry", instr_pc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr_out, e.instr);
                pop_log.push_back(e);
                pop_cyc.push_back(cyc);
            end
        end
        if (mem_resp_valid) begin
            p = pend.pop_front();
            if (p.epoch == epoch && !redirect_valid) begin
                e.pc    = p.addr;
                e.instr = p.data;
                exp_q.push_back(e);
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            p.addr  = mem_req_addr;
            p.data  = mem_word(mem_req_addr);
            p.due   = cyc + lat;
            p.epoch = epoch;
            pend.push_back(p);
            req_log.push_back(mem_req_addr);
        end
        if (redirect_valid) begin
            epoch++;
            exp_q.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        #1;
        check("redir_req_blocked", mem_req_valid, 32'd0);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic drain();
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && (pend.size() > 0 || exp_q.size() > 0 || instr_valid); i++) begin
            tick();
        end
        total++;
        assert (pend.size() == 0 && exp_q.size() == 0 && !instr_valid) else begin
            bad++;
            $error("FAIL drain observed pend=%0d exp=%0d valid=%0b expected=0/0/0",
                   pend.size(), exp_q.size(), instr_valid);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, with fetch enabled so the request gate is exercised.
        rst_n = 1'b0; fetch_en = 1'b1; mem_req_ready = 1'b1; instr_ready = 1'b1; lat = 1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", mem_req_valid, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_instr_valid", instr_valid, 32'd0);
        check("rst_instr_out", instr_out, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // 1: straight-line fetch, one-cycle memory.
        rst_n = 1'b1;
        #1;
        check("t1_first_req_valid", mem_req_valid, 32'd1);
        check("t1_first_req_addr", mem_req_addr, 32'h0);
        pop_log.delete(); pop_cyc.delete();
        repeat (8) tick();
        check("t1_pops", 32'(pop_log.size() >= 3), 32'd1);
        check("t1_pc0", pop_log[0].pc, 32'h0000_0000);
        check("t1_in0", pop_log[0].instr, 32'h0000_0013);
        check("t1_pc1", pop_log[1].pc, 32'h0000_0004);
        check("t1_in1", pop_log[1].instr, 32'h0010_0093);
        check("t1_pc2", pop_log[2].pc, 32'h0000_0008);
        check("t1_in2", pop_log[2].instr, 32'h0020_0113);
        check("t1_rate01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
        check("t1_rate12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        drain();

        // 2: decode stalled, credits cap issue at FIFO_DEPTH.
        do_redirect(32'h0);
        fetch_en = 1'b1; instr_ready = 1'b0; lat = 1;
        req_log.delete();
        repeat (8) tick();
        check("t2_req_count", 32'(req_log.size()), 32'd4);
        check("t2_addr0", req_log[0], 32'h0);
        check("t2_addr1", req_log[1], 32'h4);
        check("t2_addr2", req_log[2], 32'h8);
        check("t2_addr3", req_log[3], 32'hC);
        check("t2_stalled_valid", mem_req_valid, 32'd0);
        instr_ready = 1'b1;
        req_log.delete();
        for (int i = 0; i < 10 && req_log.size() == 0; i++) tick();
        check("t2_resume_seen", 32'(req_log.size() > 0), 32'd1);
        check("t2_resume_addr", req_log[0], 32'h10);
        drain();

        // 3: redirect with two slow responses still in flight.
        lat = 3; fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (2) tick();
        check("t3_outstanding", 32'(dut.outstanding), 32'(pend.size()));
        do_redirect(32'h0000_0103);
        #1;
        check("t3_req_valid", mem_req_valid, 32'd1);
        check("t3_req_addr", mem_req_addr, 32'h0000_0100);
        pop_log.delete();
        repeat (12) tick();
        check("t3_pops", 32'(pop_log.size() > 0), 32'd1);
        check("t3_first_pc", pop_log[0].pc, 32'h0000_0100);
        drain();

        // 4: redirect coinciding with a response and a pop.
        lat = 2; fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (6) tick();
        check("t4_pre_valid", instr_valid, 32'd1);
        check("t4_pre_resp_due", 32'(pend.size() > 0 && pend[0].due <= cyc), 32'd1);
        pre = pend.size();
        do_redirect(32'h0000_0200);
        check("t4_flushed", instr_valid, 32'd0);
        check("t4_drop_cnt", 32'(dut.drop_cnt), 32'(pre - 1));
        pop_log.delete();
        repeat (10) tick();
        check("t4_first_pc", pop_log[0].pc, 32'h0000_0200);
        drain();

        // 5: PC wrap at the top of the address space, misaligned target.
        lat = 1; fetch_en = 1'b1; instr_ready = 1'b1;
        do_redirect(32'hFFFF_FFFE);
        #1;
        check("t5_req_addr", mem_req_addr, 32'hFFFF_FFFC);
        check("t5_req_valid", mem_req_valid, 32'd1);
        pop_log.delete();
        tick();
        check("t5_wrap_addr", mem_req_addr, 32'h0000_0000);
        repeat (6) tick();
        check("t5_first_pc", pop_log[0].pc, 32'hFFFF_FFFC);
        check("t5_second_pc", pop_log[1].pc, 32'h0000_0000);
        drain();

        // 6: asynchronous reset mid-stream with three requests in flight.
        lat = 3; fetch_en = 1'b1; instr_ready = 1'b0;
        repeat (4) tick();
        check("t6_outstanding", 32'(dut.outstanding), 32'd3);
        check("t6_pre_valid", instr_valid, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req_valid", mem_req_valid, 32'd0);
        check("t6_rst_req_addr", mem_req_addr, 32'h0);
        check("t6_rst_instr_valid", instr_valid, 32'd0);
        check("t6_rst_instr_out", instr_out, 32'h0);
        check("t6_rst_instr_pc", instr_pc, 32'h0);
        pend.delete(); exp_q.delete(); epoch++;
        mem_resp_valid = 1'b0; instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_restart_valid", mem_req_valid, 32'd1);
        check("t6_restart_addr", mem_req_addr, 32'h0);
        pop_log.delete();
        repeat (10) tick();
        check("t6_first_pc", pop_log[0].pc, 32'h0);
        check("t6_first_instr", pop_log[0].instr, 32'h0000_0013);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised, pipelined instruction fetch stage. It replaces the single-cycle pc -> instr lookup with:
- a PC register;
- a valid/ready request port to instruction memory;
- in-order response handling;
- a prefetch FIFO feeding decode.

It supports backpressure from decode and redirect/flush from branch resolution. In-flight responses belonging to a stale path are dropped.

Parameters:
XLEN, 32, width of PC, address and instruction words
RESET_PC, 32'h00000000, PC loaded on reset
FIFO_DEPTH, 4, prefetch entries (power of two, >=2); also bounds outstanding requests
CNT_W, $clog2(FIFO_DEPTH)+1, width of occupancy/outstanding counters

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  when 0, no new memory requests issue; buffered instructions still drain
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored and forced to 0
mem_req_valid  out  1  request to instruction memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  word-aligned fetch address
mem_resp_valid  in  1  response data valid; responses return in request order, at most one per cycle
mem_resp_data  in  XLEN  instruction word
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head
instr_out  out  XLEN  head instruction
instr_pc  out  XLEN  PC of head instruction

Behaviour:
Reset (rst_n=0, asynchronous):
- fetch_pc=RESET_PC, resp_pc=RESET_PC.
- outstanding=0, drop_cnt=0, FIFO empty.
- mem_req_valid=0, mem_req_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.

Issue:
- mem_req_valid=1 when fetch_en && !redirect_valid && (outstanding+fifo_count) < FIFO_DEPTH.
- mem_req_addr=fetch_pc (combinational from register).
- Request handshake (valid&&ready): fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- mem_req_valid may drop without a handshake, on redirect or when fetch_en falls. Our memory permits request withdrawal.
- First request is visible in the first cycle after rst_n deasserts, if fetch_en=1.

Response:
- Each mem_resp_valid decrements outstanding.
- If drop_cnt>0: response is discarded and drop_cnt -= 1.
- Otherwise: push {resp_pc, mem_resp_data} into the FIFO; resp_pc += 4.
- Request and response in the same cycle leave outstanding unchanged.

Output:
- instr_valid = FIFO non-empty; instr_out/instr_pc = head entry.
- Pop on instr_valid&&instr_ready.
- Minimum latency from response to instr_valid is 1 cycle (registered FIFO, no bypass).
- Push and pop in the same cycle are legal at any occupancy, including full.
- The credit rule guarantees a push never hits a full FIFO.
- An overflow attempt is a design error; flag it with a simulation-only assertion.

Redirect (redirect_valid=1, highest priority):
- Next cycle: FIFO empty, fetch_pc=resp_pc={redirect_pc[XLEN-1:2],2'b00}.
- drop_cnt = outstanding_next, i.e. current outstanding, +1 if a request handshakes this cycle, -1 if a response arrives this cycle; a response arriving this cycle is discarded, never pushed.
- A pop in the same cycle is ignored, since the FIFO is flushed.
- A redirect while drop_cnt>0 accumulates the same way.
- Back-to-back redirects: the last one wins.

fetch_en=0 with requests in flight: responses are still accepted and pushed.

Decomposition:
- Package fetch_pkg: INSTR_BYTES=4, PC_ALIGN_MASK, and a fetch-entry struct/type {pc, instr} of width 2*XLEN.
- Sub-module fetch_fifo (parametrised WIDTH, DEPTH):
  - synchronous push/pop, flush input, count output;
  - registered head;
  - async active-low reset.
- Top level holds the PC registers, outstanding/drop counters and issue logic.

Test Plan:
1. Reset release, fetch_en=1, mem_req_ready=1, memory returns word at addr+1 cycle (0->00000013, 4->00100093, 8->00200113), instr_ready=1 -> instr_pc 0,4,8 with matching instr_out, one per cycle after fill.
2. instr_ready=0 with FIFO_DEPTH=4 -> exactly 4 requests issue (addr 0..C), then mem_req_valid=0; raise instr_ready -> fetch resumes at addr 10.
3. Memory latency 3 cycles, 2 requests outstanding, redirect_pc=32'h00000103 -> both stale responses dropped; next instr_pc=00000100; mem_req_addr=00000100 on the cycle after redirect.
4. Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, response not visible, drop_cnt = outstanding-1.
5. fetch_pc=FFFFFFFC via redirect -> following request addr 00000000 (wrap).
6. rst_n pulled low mid-stream with 3 outstanding -> all outputs return to reset values immediately; after release, fetch restarts at RESET_PC and no stale response is emitted.
